// File: rtl/fp16_pkg.sv
// ============================================================================
//  Module   : fp16_pkg
//  Purpose  : Shared types and constants for the FP16 round/pack datapath.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fp16_pkg;

    typedef enum logic [1:0] {
        RZ  = 2'b00,
        RNE = 2'b01,
        RM  = 2'b10,
        RP  = 2'b11
    } roundmode_t;

    localparam int          BIAS = 15;
    localparam int          EMAX = 31;
    localparam logic [15:0] QNAN = 16'h7E00;
    localparam logic [14:0] INF  = 15'h7C00;
    localparam logic [14:0] MAXF = 15'h7BFF;

    localparam int FLAG_INVALID   = 3;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_INEXACT   = 0;

endpackage

`default_nettype wire

// File: rtl/lzc.sv
// ============================================================================
//  Module   : lzc
//  Purpose  : Leading-zero counter; an all-zero input returns W.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lzc #(
    parameter int W  = 22,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  data,
    output logic [CW-1:0] count
);

    // Ascending scan: the highest set bit is the last one to write count.
    always_comb begin
        count = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (data[i]) begin
                count = CW'(W - 1 - i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fp16_round_pack.sv
// ============================================================================
//  Module   : fp16_round_pack
//  Purpose  : Two-stage normalize / round / pack of an FMA result to binary16.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp16_round_pack
    import fp16_pkg::*;
#(
    parameter int MW = 22,
    parameter int EW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          Zs,
    input  logic [EW-1:0] Ze,
    input  logic [MW-1:0] Zm,
    input  logic          Zsticky,
    input  logic          Znan,
    input  logic          Zinf,
    input  logic          Zinvalid,
    input  logic [1:0]    roundmode,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [15:0]   result,
    output logic [3:0]    flags
);

    localparam int LW = $clog2(MW + 1);
    localparam int XW = EW + 2;

    logic                 w_s2_ready;
    logic                 w_in_ready;
    logic [LW-1:0]        w_lz;
    logic signed [XW-1:0] w_ze;
    logic signed [XW-1:0] w_enorm;
    logic signed [XW-1:0] w_rsh_raw;
    logic [XW-1:0]        w_rsh_sat;
    logic [XW-1:0]        w_sub_sh;
    logic [2*MW:0]        w_rext;
    logic [MW-1:0]        w_n_m;
    logic signed [EW-1:0] w_n_e;
    logic                 w_n_st;

    logic                 r_s1_valid;
    logic                 r_s1_sign;
    logic signed [EW-1:0] r_s1_e;
    logic [MW-1:0]        r_s1_m;
    logic                 r_s1_sticky;
    logic                 r_s1_nan;
    logic                 r_s1_inf;
    logic                 r_s1_zero;
    logic                 r_s1_invalid;
    roundmode_t           r_s1_rm;

    logic                 r_out_valid;
    logic [15:0]          r_result;
    logic [3:0]           r_flags;

    assign w_s2_ready = ~r_out_valid | out_ready;
    assign w_in_ready = ~r_s1_valid | w_s2_ready;
    assign in_ready   = w_in_ready;

    lzc #(.W(MW)) u_lzc (
        .data  (Zm),
        .count (w_lz)
    );

    // ---------------- stage 1: normalize ----------------
    assign w_ze      = {{(XW-EW){Ze[EW-1]}}, Ze};
    assign w_enorm   = w_ze - $signed({{(XW-LW){1'b0}}, w_lz});
    assign w_sub_sh  = XW'(w_ze - 1);
    assign w_rsh_raw = XW'(1 - w_ze);
    assign w_rsh_sat = (w_rsh_raw > $signed(XW'(MW + 1))) ? XW'(MW + 1) : $unsigned(w_rsh_raw);
    // Low MW+1 bits catch everything shifted out, so their OR is the sticky.
    assign w_rext    = {Zm, {(MW+1){1'b0}}} >> w_rsh_sat;

    always_comb begin
        w_n_m  = Zm;
        w_n_e  = '0;
        w_n_st = 1'b0;
        if (w_enorm >= 1) begin
            w_n_m = Zm << w_lz;
            w_n_e = EW'(w_enorm);
        end else if (w_ze >= 1) begin
            w_n_m = Zm << w_sub_sh;
        end else begin
            w_n_m  = w_rext[2*MW:MW+1];
            w_n_st = |w_rext[MW:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
        end else if (w_in_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_sign    <= Zs;
                r_s1_e       <= w_n_e;
                r_s1_m       <= w_n_m;
                r_s1_sticky  <= w_n_st | Zsticky;
                r_s1_nan     <= Znan;
                r_s1_inf     <= Zinf;
                r_s1_zero    <= (Zm == '0) & ~Zsticky;
                r_s1_invalid <= Zinvalid;
                r_s1_rm      <= roundmode_t'(roundmode);
            end
        end
    end

    // ---------------- stage 2: round / pack ----------------
    logic        w_intbit;
    logic [9:0]  w_frac;
    logic        w_guard;
    logic        w_sticky;
    logic        w_inexact;
    logic        w_inc;
    logic [4:0]  w_efield;
    logic [14:0] w_sum;
    logic        w_ovf;
    logic        w_ovf_inf;
    logic [15:0] w_result;
    logic [3:0]  w_flags;

    assign w_intbit  = r_s1_m[MW-1];
    assign w_frac    = r_s1_m[MW-2:MW-11];
    assign w_guard   = r_s1_m[MW-12];
    assign w_sticky  = (|r_s1_m[MW-13:0]) | r_s1_sticky;
    assign w_inexact = w_guard | w_sticky;
    assign w_efield  = w_intbit ? r_s1_e[4:0] : 5'd0;
    // The carry out of the fraction lands in the exponent field naturally.
    assign w_sum     = {w_efield, w_frac} + 15'(w_inc);
    assign w_ovf     = (r_s1_e >= EMAX) | (w_sum[14:10] == 5'd31);

    always_comb begin
        w_inc     = 1'b0;
        w_ovf_inf = 1'b0;
        case (r_s1_rm)
            RNE: begin
                w_inc     = w_guard & (w_sticky | w_frac[0]);
                w_ovf_inf = 1'b1;
            end
            RP: begin
                w_inc     = ~r_s1_sign & w_inexact;
                w_ovf_inf = ~r_s1_sign;
            end
            RM: begin
                w_inc     = r_s1_sign & w_inexact;
                w_ovf_inf = r_s1_sign;
            end
            default: begin
                w_inc     = 1'b0;
                w_ovf_inf = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_result = {r_s1_sign, w_sum};
        w_flags  = '0;
        w_flags[FLAG_INEXACT]   = w_inexact;
        w_flags[FLAG_UNDERFLOW] = w_inexact & (w_efield == 5'd0);
        if (r_s1_nan) begin
            w_result = QNAN;
            w_flags  = '0;
            w_flags[FLAG_INVALID] = r_s1_invalid;
        end else if (r_s1_inf) begin
            w_result = {r_s1_sign, INF};
            w_flags  = '0;
        end else if (r_s1_zero) begin
            w_result = {r_s1_sign, 15'h0000};
            w_flags  = '0;
        end else if (w_ovf) begin
            w_result = {r_s1_sign, w_ovf_inf ? INF : MAXF};
            w_flags  = '0;
            w_flags[FLAG_OVERFLOW] = 1'b1;
            w_flags[FLAG_INEXACT]  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_flags     <= '0;
        end else if (w_s2_ready) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_result <= w_result;
                r_flags  <= w_flags;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign flags     = r_flags;

endmodule

`default_nettype wire

// File: tb/tb_fp16_round_pack.sv
// ============================================================================
//  Module   : tb_fp16_round_pack
//  Purpose  : Scoreboard bench for fp16_round_pack with a value-based model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp16_round_pack;
    import fp16_pkg::*;

    localparam int MW = 22;
    localparam int EW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic          Zs;
    logic [EW-1:0] Ze;
    logic [MW-1:0] Zm;
    logic          Zsticky;
    logic          Znan;
    logic          Zinf;
    logic          Zinvalid;
    logic [1:0]    roundmode;
    logic          out_valid;
    logic          out_ready;
    logic [15:0]   result;
    logic [3:0]    flags;

    int checks = 0;
    int errors = 0;
    logic [19:0] sbq[$];

    always #5 clk = ~clk;

    fp16_round_pack #(.MW(MW), .EW(EW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Zs        (Zs),
        .Ze        (Ze),
        .Zm        (Zm),
        .Zsticky   (Zsticky),
        .Znan      (Znan),
        .Zinf      (Zinf),
        .Zinvalid  (Zinvalid),
        .roundmode (roundmode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: value = Zm * 2^(Ze-36). Quantise to the binary16 ulp of the
    // value's binade (subnormal binade below 1) and round the integer quotient.
    function automatic logic [19:0] model(input bit s, input int ze, input int zm, input bit st,
                                          input bit nan, input bit inf, input bit inv, input int rm);
        int p, e_b, ef, sh, n;
        longint q, enc;
        bit g, sk, inexact, inc, to_inf;
        if (nan) return {16'h7E00, inv, 3'b000};
        if (inf) return {s, 15'h7C00, 4'b0000};
        if (zm == 0 && !st) return {s, 15'h0000, 4'b0000};
        p = 0;
        for (int i = 0; i < MW; i++) if ((zm >> i) & 1) p = i;
        e_b = ze - (MW - 1 - p);
        ef  = (e_b < 1) ? 1 : e_b;
        sh  = ze - 11 - ef;
        if (sh >= 0) begin
            q = longint'(zm) << sh; g = 0; sk = 0;
        end else begin
            n = -sh;
            if (n >= 23) begin
                q = 0; g = 0; sk = (zm != 0);
            end else begin
                q  = longint'(zm) >> n;
                g  = (zm >> (n - 1)) & 1;
                sk = (longint'(zm) & ((longint'(1) << (n - 1)) - 1)) != 0;
            end
        end
        sk = sk | st;
        inexact = g | sk;
        case (rm)
            1:       inc = g & (sk | q[0]);
            2:       inc = s & inexact;
            3:       inc = !s & inexact;
            default: inc = 0;
        endcase
        enc = (longint'(ef - 1) << 10) + q + longint'(inc);
        if (enc >= 64'h7C00) begin
            to_inf = (rm == 1) || (rm == 3 && !s) || (rm == 2 && s);
            return {s, to_inf ? 15'h7C00 : 15'h7BFF, 4'b0101};
        end
        return {s, enc[14:0], 1'b0, 1'b0, (e_b < 1) & inexact, inexact};
    endfunction

    // Presents one beat and pushes its expected response on acceptance.
    task automatic send(input logic s, input int ze, input logic [MW-1:0] zm, input logic st,
                        input logic nan, input logic inf, input logic inv, input logic [1:0] rm,
                        input logic [19:0] exp);
        Zs = s; Ze = EW'(ze); Zm = zm; Zsticky = st;
        Znan = nan; Zinf = inf; Zinvalid = inv; roundmode = rm;
        in_valid = 1'b1;
        for (int t = 0; t < 64; t++) begin
            @(negedge clk);
            if (in_ready && !reset) begin
                sbq.push_back(exp);
                @(posedge clk); #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        checks++; errors++;
        $display("FAIL accept_timeout: in_ready stayed 0, expected 1");
        in_valid = 1'b0;
    endtask

    task automatic send_rand();
        logic s, st, nan, inf, inv;
        int ze, zm, rm, k;
        s   = 1'($urandom % 2);
        ze  = int'($urandom_range(0, 65)) - 25;
        zm  = int'(($urandom & 32'h3FFFFF) >> $urandom_range(0, 21));
        if (zm == 0) zm = 1;
        st  = 1'($urandom % 2);
        k   = int'($urandom % 16);
        nan = (k == 0);
        inf = (k == 1);
        inv = nan & 1'($urandom % 2);
        rm  = int'($urandom % 4);
        send(s, ze, MW'(zm), st, nan, inf, inv, 2'(rm), model(s, ze, zm, st, nan, inf, inv, rm));
    endtask

    task automatic drain();
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (sbq.size() == 0) return;
        end
        checks++; errors++;
        $display("FAIL drain_timeout: %0d beats outstanding, expected 0", sbq.size());
    endtask

    // Monitor: every accepted output is matched against the queue head.
    always @(negedge clk) begin : mon
        logic [19:0] e;
        if (reset) begin
            sbq.delete();
        end else if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_output: got %h/%b, expected no output", result, flags);
            end else begin
                e = sbq.pop_front();
                check("result", 32'(result), 32'(e[19:4]));
                check("flags",  32'(flags),  32'(e[3:0]));
            end
        end
    end

    bit done;

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        Zs = 0; Ze = '0; Zm = '0; Zsticky = 0; Znan = 0; Zinf = 0; Zinvalid = 0; roundmode = 2'b01;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("reset_in_ready",  32'(in_ready),  32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_result",    32'(result),    32'h0);
        check("reset_flags",     32'(flags),     32'h0);

        // Latency: accepted beat appears on the second edge after acceptance.
        send(0, 15, 22'h200000, 0, 0, 0, 0, 2'b01, {16'h3C00, 4'b0000});
        check("latency_early", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check("latency_2cyc",  32'(out_valid), 32'd1);

        send(0, 15, 22'h200400, 0, 0, 0, 0, 2'b01, {16'h3C00, 4'b0001});
        send(0, 15, 22'h200400, 0, 0, 0, 0, 2'b11, {16'h3C01, 4'b0001});
        send(1, 15, 22'h200400, 0, 0, 0, 0, 2'b10, {16'hBC01, 4'b0001});
        send(0, 15, 22'h200C00, 0, 0, 0, 0, 2'b01, {16'h3C02, 4'b0001});
        send(0, 31, 22'h200000, 0, 0, 0, 0, 2'b01, {16'h7C00, 4'b0101});
        send(0, 31, 22'h200000, 0, 0, 0, 0, 2'b00, {16'h7BFF, 4'b0101});
        send(0, 30, 22'h3FFFFF, 0, 0, 0, 0, 2'b01, {16'h7C00, 4'b0101});
        send(0, -9, 22'h200000, 0, 0, 0, 0, 2'b01, {16'h0001, 4'b0000});
        send(0, -9, 22'h200000, 1, 0, 0, 0, 2'b11, {16'h0002, 4'b0011});
        send(0, 0,  22'h3FFFFF, 0, 0, 0, 0, 2'b01, {16'h0400, 4'b0011});
        send(0, 20, 22'h000800, 0, 0, 0, 0, 2'b01, {16'h2800, 4'b0000});
        send(0, 20, 22'h000800, 0, 1, 0, 1, 2'b01, {16'h7E00, 4'b1000});
        send(1, 20, 22'h000800, 0, 0, 1, 0, 2'b01, {16'hFC00, 4'b0000});
        send(1, 20, 22'h000000, 0, 0, 0, 0, 2'b01, {16'h8000, 4'b0000});
        drain();

        // Backpressure: consumer stalls for three cycles while four beats stream.
        @(posedge clk); #1;
        out_ready = 1'b0;
        fork
            begin
                send(0, 15, 22'h200000, 0, 0, 0, 0, 2'b01, {16'h3C00, 4'b0000});
                send(0, 16, 22'h200000, 0, 0, 0, 0, 2'b01, {16'h4000, 4'b0000});
                send(1, 17, 22'h200000, 0, 0, 0, 0, 2'b01, {16'hC400, 4'b0000});
                send(0, 18, 22'h300000, 0, 0, 0, 0, 2'b01, {16'h4A00, 4'b0000});
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                check("bp_in_ready_low", 32'(in_ready), 32'd0);
                check("bp_out_held",     32'(result),   32'h3C00);
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset in the middle of a stream discards everything in flight.
        send(0, 15, 22'h200000, 0, 0, 0, 0, 2'b01, {16'h3C00, 4'b0000});
        send(0, 16, 22'h200000, 0, 0, 0, 0, 2'b01, {16'h4000, 4'b0000});
        reset = 1'b1;
        @(posedge clk); #1;
        check("midreset_out_valid", 32'(out_valid), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("midreset_in_ready",  32'(in_ready),  32'd1);
        check("midreset_out_valid2", 32'(out_valid), 32'd0);

        // Randomised traffic with random consumer stalls.
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    send_rand();
                    if ($urandom % 4 == 0) begin
                        @(posedge clk); #1;
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom % 4) != 0;
                end
            end
        join
        out_ready = 1'b1;
        drain();
        check("final_queue_empty", 32'(sbq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fp16_round_pack.md
Name: fp16_round_pack

Overview:
- Output-side counterpart of the FP16 operand unpacker.
- Takes an unrounded sign/exponent/mantissa result plus special-case flags from the FMA datapath. Normalizes it, rounds it per the rounding mode and packs it into IEEE-754 binary16 with exception flags.
- 2-stage pipeline: stage 1 normalize, stage 2 round/pack.
- Valid/ready handshake on both sides; sits between the FMA adder stage and the result register.

Parameters:
- MW, 22, input mantissa width; bit MW-1 is the integer bit position (MW >= 14).
- EW, 8, signed biased exponent width (two's complement).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- Zs  in  1  result sign
- Ze  in  EW  signed biased exponent; value = Zm/2^(MW-1) * 2^(Ze-15)
- Zm  in  MW  unrounded mantissa, may have leading zeros
- Zsticky  in  1  OR of bits already discarded upstream
- Znan  in  1  result is NaN
- Zinf  in  1  result is infinity
- Zinvalid  in  1  invalid-operation flag from upstream
- roundmode  in  2  00 RZ, 01 RNE, 10 RM (toward -inf), 11 RP (toward +inf)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  16  packed binary16
- flags  out  4  {invalid, overflow, underflow, inexact}

Behaviour:
- Reset: both stage valids = 0, out_valid = 0, result = 16'h0000, flags = 4'b0. Reset mid-operation discards in-flight beats; in_ready = 1 the cycle after reset deasserts.
- Handshake:
  - Transfer occurs when valid & ready on the same edge.
  - in_ready = ~s1_valid | s2_ready, where s2_ready = ~out_valid | out_ready.
  - Stalled stages hold all contents.
  - out_valid/result/flags hold stable until accepted.
  - Full throughput: one beat per cycle when out_ready = 1.
- Latency: 2 cycles from accepted input to out_valid.
- Stage 1 (normalize), computed combinationally on input, registered into s1:
  - lz = leading zeros of Zm.
  - If Zm == 0: mark zero.
  - If Ze - lz >= 1: shift left by lz, e = Ze - lz.
  - Else if Ze >= 1: shift left by Ze-1, e = 0 (subnormal).
  - Else (Ze <= 0): shift right by 1-Ze, saturated at MW+1. Shifted-out bits OR into sticky; e = 0.
  - Registers sign, e (EW bits), normalized mantissa, sticky, specials, roundmode.
- Stage 2 (round/pack), result bit fields:
  - Fraction field = m[MW-2:MW-11]; integer bit m[MW-1].
  - Guard = m[MW-12]; sticky = OR(m[MW-13:0], Zsticky, stage-1 sticky).
  - Increment rules:
    - RNE: G & (S | lsb).
    - RZ: 0.
    - RP: ~s & (G|S).
    - RM: s & (G|S).
  - Exponent field = e when integer bit is 1, else 0.
  - The rounded 11-bit {intbit, frac} carry-out increments the exponent. A subnormal rounding up into 0x0400 becomes the smallest normal naturally.
  - inexact = G|S.
  - underflow = inexact & (exponent field 0 before rounding).
- Overflow: pre-round e >= 31, or rounding carries the exponent to 31.
  - Sets overflow and inexact.
  - Result is inf (7C00) or max finite (7BFF) by mode:
    - RNE: inf.
    - RZ: max.
    - RP: inf if positive, else max.
    - RM: inf if negative, else max.
- Specials, in priority order, override rounding:
  - Znan: 16'h7E00, invalid = Zinvalid, other flags 0.
  - Zinf: {Zs,15'h7C00}, flags 0.
  - Zm == 0 and Zsticky == 0: {Zs,15'h0}, flags 0.
- Simultaneous stall and reset: reset wins.

Decomposition:
- Package fp16_pkg holds:
  - roundmode_t enum (RZ, RNE, RM, RP).
  - Constants BIAS = 15, EMAX = 31, QNAN = 16'h7E00, INF = 15'h7C00, MAXF = 15'h7BFF.
  - Flag bit indices.
- One sub-module: lzc (parameterized leading-zero counter, MW-bit input, clog2(MW+1) output), used in stage 1.

Test Plan (MW = 22):
- Zs=0, Ze=15, Zm=22'h200000, RNE -> result 3C00, flags 0000, out_valid exactly 2 cycles after accept.
- Tie to even: Ze=15, Zm=22'h200400, Zsticky=0.
  - RNE -> 3C00, inexact only.
  - RP -> 3C01.
  - RM with Zs=1 -> BC01.
- Overflow: Ze=31, Zm=22'h200000.
  - RNE -> 7C00, flags 0101.
  - RZ -> 7BFF, flags 0101.
- Subnormal: Ze=-9, Zm=22'h200000 -> 0001, flags 0000.
  - Same with Zsticky=1 under RP -> 0002, flags 0011.
- Normalize: Ze=20, Zm=22'h000800 (lz=10) -> exponent 10, result 2800.
  - Znan=1, Zinvalid=1 -> 7E00, flags 1000.
- Backpressure: stream 4 beats with out_ready low for 3 cycles.
  - in_ready drops once both stages fill.
  - No beat lost or duplicated; order preserved.
  - Assert reset mid-stream -> out_valid = 0 next cycle.
